// File: rtl/jump_target_encoder_if.sv
// Request/response bundle for jump_target_encoder: request handshake with jump operands,
// result handshake with the encoded word, plus flush and the fault counter.
interface jump_target_encoder_if #(
    parameter int CNT_W = 16
);
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      target_i;
    logic [31:0]      pc_plus4_i;
    logic             link_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      instr_o;
    logic [1:0]       fault_o;
    logic [CNT_W-1:0] fault_cnt_o;

    // Requester / consumer side
    modport master (
        output flush_i, req_valid_i, target_i, pc_plus4_i, link_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, instr_o, fault_o, fault_cnt_o
    );

    // Encoder side
    modport slave (
        input  flush_i, req_valid_i, target_i, pc_plus4_i, link_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, instr_o, fault_o, fault_cnt_o
    );
endinterface

// File: rtl/jump_target_encoder.sv
// Encodes a jump target into a J/JAL word with alignment/region checks, buffered in an
// in-order result FIFO. Optional saturating fault counter: JUMP_ENC_FAULT_CNT_EN.
module jump_target_encoder #(
    parameter logic [5:0] OPC_J   = 6'b000010,
    parameter logic [5:0] OPC_JAL = 6'b000011,
    parameter int         DEPTH   = 4,
    parameter int         CNT_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    jump_target_encoder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PART  = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    occ_state_e    state_q, state_d;
    logic [AW:0]   occ_q, occ_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [1:0]    fault_mem [DEPTH];

    logic          push, pop, accept;
    logic [1:0]    enc_fault;
    logic [31:0]   enc_instr;

    // Only the region nibble of PC+4 takes part in the check.
    logic          unused_pc_bits;
    assign unused_pc_bits = ^bus.pc_plus4_i[27:0];

    // Encode path
    assign enc_fault[0] = (bus.target_i[1:0] != 2'b00);
    assign enc_fault[1] = (bus.target_i[31:28] != bus.pc_plus4_i[31:28]);
    assign enc_instr    = (|enc_fault) ? 32'h0
                        : {(bus.link_i ? OPC_JAL : OPC_J), bus.target_i[27:2]};

    // Ready comes straight from the registered state, never from rsp_ready_i.
    assign bus.req_ready_o = (state_q != ST_FULL);
    assign bus.rsp_valid_o = (state_q != ST_EMPTY);

    assign accept = bus.req_valid_i && bus.req_ready_o && !bus.flush_i;
    assign push   = accept;
    assign pop    = bus.rsp_valid_o && bus.rsp_ready_i && !bus.flush_i;

    assign bus.instr_o = bus.rsp_valid_o ? instr_mem[rd_ptr_q] : 32'h0;
    assign bus.fault_o = bus.rsp_valid_o ? fault_mem[rd_ptr_q] : 2'b00;

    always_comb begin
        state_d  = state_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush_i) begin
            state_d  = ST_EMPTY;
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      occ_d = occ_q + (AW+1)'(1);
            else if (pop && !push) occ_d = occ_q - (AW+1)'(1);
            unique case (state_q)
                ST_EMPTY: if (push) state_d = ST_PART;
                ST_PART: begin
                    if (push && !pop && (occ_q == (AW+1)'(DEPTH - 1)))
                        state_d = ST_FULL;
                    else if (pop && !push && (occ_q == (AW+1)'(1)))
                        state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop && !push) state_d = ST_PART;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_EMPTY;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only visible while rsp_valid_o is high.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= enc_instr;
            fault_mem[wr_ptr_q] <= enc_fault;
        end
    end

`ifdef JUMP_ENC_FAULT_CNT_EN
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (accept && (|enc_fault) && !(&fault_cnt_q))
            fault_cnt_d = fault_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) fault_cnt_q <= '0;
        else        fault_cnt_q <= fault_cnt_d;
    end

    assign bus.fault_cnt_o = fault_cnt_q;
`else
    assign bus.fault_cnt_o = '0;
`endif

endmodule

// File: tb/tb_jump_target_encoder.sv
// Directed bench for jump_target_encoder: scoreboard queue of expected results, checked
// with immediate assertions as the FIFO head is consumed.
module tb_jump_target_encoder;
    localparam int CNT_W = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jump_target_encoder_if #(.CNT_W(CNT_W)) bus ();

    jump_target_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    exp_t              sb[$];
    logic [CNT_W-1:0]  mcnt = '0;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [31:0] t, input logic [31:0] p4, input logic l);
        exp_t e;
        e.fault[0] = (t[1:0] != 2'b00);
        e.fault[1] = (t[31:28] != p4[31:28]);
        e.instr    = (e.fault != 2'b00) ? 32'h0 : {(l ? 6'b000011 : 6'b000010), t[27:2]};
        return e;
    endfunction

    // Evaluates the handshakes present before the coming edge, scoreboards them, then
    // advances one clock and returns 1ns past the edge.
    task automatic tick(output bit acc);
        bit pop;
        exp_t e;
        acc = bus.req_valid_i && bus.req_ready_o && !bus.flush_i;
        pop = bus.rsp_valid_o && bus.rsp_ready_i && !bus.flush_i;
        chk("rsp_valid_vs_sb", {31'd0, bus.rsp_valid_o}, {31'd0, (sb.size() != 0)});
        if (pop && sb.size() != 0) begin
            e = sb.pop_front();
            chk("head_instr", bus.instr_o, e.instr);
            chk("head_fault", {30'd0, bus.fault_o}, {30'd0, e.fault});
        end
        if (acc) begin
            e = model(bus.target_i, bus.pc_plus4_i, bus.link_i);
            sb.push_back(e);
`ifdef JUMP_ENC_FAULT_CNT_EN
            if (e.fault != 2'b00 && mcnt != '1) mcnt = mcnt + 1'b1;
`endif
        end
        if (bus.flush_i) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] t, input logic [31:0] p4, input logic l);
        bus.req_valid_i = 1'b1;
        bus.target_i    = t;
        bus.pc_plus4_i  = p4;
        bus.link_i      = l;
    endtask

    bit acc;
    int n;

    initial begin
        bus.flush_i     = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.target_i    = '0;
        bus.pc_plus4_i  = '0;
        bus.link_i      = 1'b0;
        bus.rsp_ready_i = 1'b0;

        // Reset state
        #2;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_fault", {30'd0, bus.fault_o}, 32'd0);
        chk("rst_cnt", 32'(bus.fault_cnt_o), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);

        // 1: J, next-cycle latency
        req(32'h0040_0020, 32'h0040_0004, 1'b0);
        tick(acc);
        bus.req_valid_i = 1'b0;
        chk("t1_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
        chk("t1_instr", bus.instr_o, 32'h0810_0008);
        chk("t1_fault", {30'd0, bus.fault_o}, 32'd0);
        bus.rsp_ready_i = 1'b1;
        tick(acc);

        // 2: JAL
        req(32'h0040_0020, 32'h0040_0004, 1'b1);
        tick(acc);
        bus.req_valid_i = 1'b0;
        chk("t2_instr", bus.instr_o, 32'h0C10_0008);
        tick(acc);

        // 3: region fault
        req(32'h1000_0000, 32'h0040_0004, 1'b0);
        tick(acc);
        bus.req_valid_i = 1'b0;
        chk("t3_instr", bus.instr_o, 32'h0);
        chk("t3_fault", {30'd0, bus.fault_o}, 32'd2);
        chk("t3_cnt", 32'(bus.fault_cnt_o), 32'(mcnt));
`ifdef JUMP_ENC_FAULT_CNT_EN
        chk("t3_cnt_abs", 32'(bus.fault_cnt_o), 32'd1);
`endif
        tick(acc);

        // 4: both faults; optionally drive the counter into saturation
        req(32'hF000_0002, 32'h0040_0004, 1'b0);
        tick(acc);
        chk("t4_fault", {30'd0, bus.fault_o}, 32'd3);
        chk("t4_instr", bus.instr_o, 32'h0);
`ifdef JUMP_ENC_FAULT_CNT_EN
        for (int i = 0; i < 65540; i++) tick(acc);
        chk("t4_cnt_sat", 32'(bus.fault_cnt_o), 32'h0000_FFFF);
`endif
        chk("t4_cnt", 32'(bus.fault_cnt_o), 32'(mcnt));
        bus.req_valid_i = 1'b0;
        tick(acc);
        tick(acc);
        chk("t4_drained", {31'd0, bus.rsp_valid_o}, 32'd0);

        // 5: back-pressure, five requests against a four-deep FIFO
        bus.rsp_ready_i = 1'b0;
        n = 0;
        req(32'h0000_1000, 32'h0000_0004, 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick(acc);
            if (acc) begin
                n++;
                req(32'h0000_1000 + 32'(n) * 32'h10, 32'h0000_0004, n[0]);
            end
        end
        chk("t5_accepted", 32'(n), 32'd4);
        chk("t5_ready_full", {31'd0, bus.req_ready_o}, 32'd0);
        bus.rsp_ready_i = 1'b1;
        for (int c = 0; c < 8 && (n < 5 || sb.size() != 0); c++) begin
            tick(acc);
            if (acc) begin
                n++;
                bus.req_valid_i = 1'b0;
            end
        end
        chk("t5_all_done", 32'(n), 32'd5);
        chk("t5_empty", {31'd0, bus.rsp_valid_o}, 32'd0);

        // 6a: flush with a same-cycle request
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(32'h0000_2000 + 32'(i) * 4, 32'h0000_0004, 1'b0);
            tick(acc);
        end
        bus.flush_i = 1'b1;
        req(32'h0000_3000, 32'h0000_0004, 1'b1);
        tick(acc);
        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        chk("t6_flush_empty", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("t6_flush_instr", bus.instr_o, 32'h0);
        chk("t6_flush_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("t6_flush_cnt", 32'(bus.fault_cnt_o), 32'(mcnt));

        // 6b: async reset mid-burst
        for (int i = 0; i < 3; i++) begin
            req(32'h0000_4000 + 32'(i) * 4, 32'h0000_0004, 1'b1);
            tick(acc);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("t6_rst_instr", bus.instr_o, 32'h0);
        chk("t6_rst_fault", {30'd0, bus.fault_o}, 32'd0);
        chk("t6_rst_cnt", 32'(bus.fault_cnt_o), 32'd0);
        sb.delete();
        mcnt = '0;
        bus.req_valid_i = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_post_rst_ready", {31'd0, bus.req_ready_o}, 32'd1);

        // Post-reset sanity transaction
        bus.rsp_ready_i = 1'b1;
        req(32'h0040_0020, 32'h0040_0004, 1'b0);
        tick(acc);
        bus.req_valid_i = 1'b0;
        chk("post_instr", bus.instr_o, 32'h0810_0008);
        tick(acc);
        chk("post_empty", {31'd0, bus.rsp_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
